// File: rtl/onchip_ram_arbiter_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package onchip_ram_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 20490;

  // Index of a requesting master (0 = processor data master, 1 = DMA/peripheral).
  typedef logic mid_t;

  // One read-tag pipeline stage: which master the returning data belongs to,
  // and whether the access was out of range (data must then read as zero).
  typedef struct packed {
    logic valid;
    mid_t mid;
    logic oor;
  } rd_tag_t;

endpackage

// File: rtl/onchip_ram_arbiter_if.sv
// Avalon-style master bus for one arbiter client.
// Latency: n/a (signal bundle only).
// Backpressure: waitrequest high means the request is held off this cycle.
// Ports: address/byteenable/read/write/writedata driven by the master;
//        waitrequest/readdata/readdatavalid driven by the arbiter.
interface onchip_ram_arbiter_if
  import onchip_ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a registered priority pointer.
// Latency: grant is combinational from req/hold/prio; prio updates on the clock.
// Backpressure: hold or reset suppresses all grants.
// Ports: clk, reset (async active-high), req[1:0], hold, gnt[1:0] (one-hot or zero).
module rr_arb2
  import onchip_ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  mid_t prio;

  always_comb begin
    gnt = 2'b00;
    if (!reset && !hold) begin
      if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // After a grant the pointer names the master that lost (or did not ask).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       prio <= 1'b0;
    else if (gnt[0]) prio <= 1'b1;
    else if (gnt[1]) prio <= 1'b0;
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Shares one single-port RAM between two Avalon masters, round-robin, with range check.
// Latency: grant/strobes same cycle as request; read data RD_LATENCY cycles after accept.
// Backpressure: losing or held-off master sees waitrequest high; one access per cycle.
// Ports: clk, reset (async active-high), m0/m1 master buses, ram_* RAM side,
//        hold (freeze grants), idle (no grant, nothing in flight), oor_err (sticky).
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  onchip_ram_arbiter_if.slave m0,
  onchip_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  input  logic                hold,
  output logic                idle,
  output logic                oor_err
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        any_gnt;
  logic        sel_m1;
  logic        sel_read;
  logic        sel_write;
  logic        in_range;
  logic        in_flight;
  rd_tag_t     tag_in;
  rd_tag_t     tag_out;
  rd_tag_t     tag_q [RD_LATENCY];
  logic [DATA_W-1:0] rsp_data;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .hold  (hold),
    .gnt   (gnt)
  );

  assign any_gnt = |gnt;
  assign sel_m1  = gnt[1];

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

  // Request mux: with no grant the m0 fields pass through, but the strobes stay low.
  always_comb begin
    ram_address    = sel_m1 ? m1.address    : m0.address;
    ram_byteenable = sel_m1 ? m1.byteenable : m0.byteenable;
    ram_writedata  = sel_m1 ? m1.writedata  : m0.writedata;
    sel_read       = sel_m1 ? m1.read       : m0.read;
    sel_write      = sel_m1 ? m1.write      : m0.write;
  end

  assign in_range       = {1'b0, ram_address} < DEPTH_W;
  assign ram_chipselect = any_gnt & in_range;
  assign ram_write      = ram_chipselect & sel_write;
  assign ram_clken      = ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    oor_err <= 1'b0;
    else if (any_gnt & ~in_range) oor_err <= 1'b1;
  end

  // Out-of-range reads still get a tag so the master sees its response (as zero).
  always_comb begin
    tag_in       = '0;
    tag_in.valid = any_gnt & sel_read;
    tag_in.mid   = sel_m1;
    tag_in.oor   = ~in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight | tag_q[i].valid;
  end

  assign idle = ~any_gnt & ~in_flight;

  // Response demux: only the tagged master sees data; everyone else reads zero.
  assign tag_out  = tag_q[RD_LATENCY-1];
  assign rsp_data = tag_out.oor ? '0 : ram_readdata;

  assign m0.readdatavalid = tag_out.valid & (tag_out.mid == 1'b0);
  assign m1.readdatavalid = tag_out.valid & (tag_out.mid == 1'b1);
  assign m0.readdata      = m0.readdatavalid ? rsp_data : '0;
  assign m1.readdata      = m1.readdatavalid ? rsp_data : '0;

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
module tb_onchip_ram_arbiter;
  import onchip_ram_arb_pkg::*;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } mreq_t;

  typedef struct packed {
    logic  rst;
    logic  hold;
    mreq_t m1;
    mreq_t m0;
  } stim_t;

  typedef struct packed {
    logic        w0;
    logic        w1;
    logic        rv0;
    logic        rv1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        cs;
    logic        wr;
    logic        clken;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        idle;
    logic        oor;
  } obs_t;

  typedef struct {
    int          d;
    int          due;
    int          mid;
    logic [31:0] data;
  } resp_t;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  stim_t stim [2];
  obs_t  obs  [2];
  int    errors = 0;
  int    checks = 0;

  // Lane g runs a DUT with RD_LATENCY = g+1 against its own RAM stand-in.
  for (genvar g = 0; g < 2; g++) begin : lane
    onchip_ram_arbiter_if m0_if ();
    onchip_ram_arbiter_if m1_if ();
    logic [14:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        ram_chipselect, ram_write, ram_clken, idle, oor_err;
    logic [31:0] mem [0:32767];
    logic [31:0] rq1, rq2;

    assign m0_if.address    = stim[g].m0.addr;
    assign m0_if.byteenable = stim[g].m0.be;
    assign m0_if.read       = stim[g].m0.rd;
    assign m0_if.write      = stim[g].m0.wr;
    assign m0_if.writedata  = stim[g].m0.wd;
    assign m1_if.address    = stim[g].m1.addr;
    assign m1_if.byteenable = stim[g].m1.be;
    assign m1_if.read       = stim[g].m1.rd;
    assign m1_if.write      = stim[g].m1.wr;
    assign m1_if.writedata  = stim[g].m1.wd;

    onchip_ram_arbiter #(.RD_LATENCY(g + 1)) dut (
      .clk            (clk),
      .reset          (stim[g].rst),
      .m0             (m0_if),
      .m1             (m1_if),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_writedata  (ram_writedata),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_clken      (ram_clken),
      .ram_readdata   (ram_readdata),
      .hold           (stim[g].hold),
      .idle           (idle),
      .oor_err        (oor_err)
    );

    always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
        if (ram_write) begin
          for (int b = 0; b < 4; b++)
            if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end else begin
          rq1 <= mem[ram_address];
        end
      end
      rq2 <= rq1;
    end

    assign ram_readdata = (g == 0) ? rq1 : rq2;

    assign obs[g] = {m0_if.waitrequest, m1_if.waitrequest,
                     m0_if.readdatavalid, m1_if.readdatavalid,
                     m0_if.readdata, m1_if.readdata,
                     ram_chipselect, ram_write, ram_clken,
                     ram_address, ram_byteenable, ram_writedata,
                     idle, oor_err};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          prio_m [2];
  bit          oor_m  [2];
  int          cyc    [2];
  resp_t       q [$];
  logic [31:0] shadow [2][32768];

  task automatic model_step(input int d);
    stim_t s;
    obs_t  o;
    mreq_t m;
    int    g, hit, pending;
    bit    r0, r1, inr;
    bit    erv [2];
    logic [31:0] erd [2];
    string p;
    s = stim[d];
    o = obs[d];
    p = $sformatf("u%0d.", d);
    if (s.rst) begin
      chk({p, "rst_wait0"}, o.w0, 1);
      chk({p, "rst_wait1"}, o.w1, 1);
      chk({p, "rst_rv"}, {o.rv0, o.rv1}, 0);
      chk({p, "rst_rd0"}, o.rd0, 0);
      chk({p, "rst_rd1"}, o.rd1, 0);
      chk({p, "rst_cs_wr"}, {o.cs, o.wr}, 0);
      chk({p, "rst_clken"}, o.clken, 0);
      chk({p, "rst_idle"}, o.idle, 1);
      chk({p, "rst_oor"}, o.oor, 0);
      prio_m[d] = 0;
      oor_m[d]  = 0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == d) q.delete(i);
      cyc[d]++;
      return;
    end
    r0 = !s.hold && (s.m0.rd || s.m0.wr);
    r1 = !s.hold && (s.m1.rd || s.m1.wr);
    if (r0 && r1)  g = int'(prio_m[d]);
    else if (r0)   g = 0;
    else if (r1)   g = 1;
    else           g = -1;
    m   = (g == 1) ? s.m1 : s.m0;
    inr = (g >= 0) && (int'(m.addr) < 20490);
    chk({p, "wait0"}, o.w0, (g != 0));
    chk({p, "wait1"}, o.w1, (g != 1));
    chk({p, "cs"}, o.cs, inr);
    chk({p, "ram_write"}, o.wr, inr && m.wr);
    chk({p, "clken"}, o.clken, 1);
    if (g >= 0) begin
      chk({p, "ram_addr"}, o.addr, m.addr);
      chk({p, "ram_be"}, o.be, m.be);
      chk({p, "ram_wd"}, o.wd, m.wd);
    end
    hit = -1;
    pending = 0;
    foreach (q[i]) if (q[i].d == d) begin
      pending++;
      if (hit < 0) hit = i;
    end
    erv[0] = 0; erv[1] = 0; erd[0] = 0; erd[1] = 0;
    if (hit >= 0 && q[hit].due == cyc[d]) begin
      erv[q[hit].mid] = 1;
      erd[q[hit].mid] = q[hit].data;
    end
    chk({p, "rv0"}, o.rv0, erv[0]);
    chk({p, "rv1"}, o.rv1, erv[1]);
    chk({p, "rd0"}, o.rd0, erd[0]);
    chk({p, "rd1"}, o.rd1, erd[1]);
    chk({p, "idle"}, o.idle, (g < 0) && (pending == 0));
    chk({p, "oor_err"}, o.oor, oor_m[d]);
    if (hit >= 0 && q[hit].due == cyc[d]) q.delete(hit);
    if (g >= 0) begin
      prio_m[d] = (g == 0);
      if (!inr) oor_m[d] = 1;
      if (m.rd) q.push_back('{d: d, due: cyc[d] + d + 1, mid: g,
                              data: inr ? shadow[d][m.addr] : 32'h0});
      else if (m.wr && inr)
        for (int b = 0; b < 4; b++)
          if (m.be[b]) shadow[d][m.addr][8*b +: 8] = m.wd[8*b +: 8];
    end
    cyc[d]++;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- directed stimulus ----------------
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic setm(input int d, input int n, input logic rd, input logic wr,
                      input logic [14:0] addr, input logic [3:0] be, input logic [31:0] wd);
    mreq_t r;
    r = {rd, wr, addr, be, wd};
    if (n == 0) stim[d].m0 = r;
    else        stim[d].m1 = r;
  endtask

  task automatic clr(input int d);
    stim[d].m0 = '0;
    stim[d].m1 = '0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      stim[d] = '0;
      stim[d].rst = 1'b1;
    end
    go();
    go();
    mid();
    for (int d = 0; d < 2; d++) begin
      chk("lit_rst_wait", {obs[d].w0, obs[d].w1}, 2'b11);
      chk("lit_rst_clken", obs[d].clken, 0);
      chk("lit_rst_idle", obs[d].idle, 1);
    end
    go();
    stim[0].rst = 1'b0;
    stim[1].rst = 1'b0;

    // m1 seeds 0x20, then m0 write/read 0x10
    setm(0, 1, 0, 1, 15'h20, 4'hF, 32'hCAFEF00D);
    go();
    clr(0);
    setm(0, 0, 0, 1, 15'h10, 4'hF, 32'h12345678);
    mid();
    chk("lit_wr_wait0", obs[0].w0, 0);
    chk("lit_wr_cs_wr", {obs[0].cs, obs[0].wr}, 2'b11);
    go();
    setm(0, 0, 1, 0, 15'h10, 4'hF, 32'h0);
    mid();
    chk("lit_rd_wait0", obs[0].w0, 0);
    chk("lit_rd_cs_wr", {obs[0].cs, obs[0].wr}, 2'b10);
    go();
    clr(0);
    mid();
    chk("lit_rd_rv", {obs[0].rv0, obs[0].rv1}, 2'b10);
    chk("lit_rd_data", obs[0].rd0, 32'h12345678);
    go();

    // reset pulse, then contested continuous reads start at m0
    stim[0].rst = 1'b1;
    go();
    go();
    stim[0].rst = 1'b0;
    setm(0, 0, 1, 0, 15'h10, 4'hF, 32'h0);
    setm(0, 1, 1, 0, 15'h20, 4'hF, 32'h0);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) clr(0);
      mid();
      if (k < 6) begin
        chk("lit_alt_wait0", obs[0].w0, k % 2);
        chk("lit_alt_wait1", obs[0].w1, 1 - (k % 2));
      end
      chk("lit_alt_rv0", obs[0].rv0, (k % 2) == 1);
      chk("lit_alt_rv1", obs[0].rv1, (k >= 2) && (k % 2 == 0));
      chk("lit_alt_rd0", obs[0].rd0, ((k % 2) == 1) ? 32'h12345678 : 32'h0);
      chk("lit_alt_rd1", obs[0].rd1, ((k >= 2) && (k % 2 == 0)) ? 32'hCAFEF00D : 32'h0);
      go();
    end

    // byte-enable merge
    setm(0, 0, 0, 1, 15'h30, 4'hF, 32'hAABBCCDD);
    go();
    setm(0, 0, 0, 1, 15'h30, 4'b0101, 32'h11223344);
    go();
    setm(0, 0, 1, 0, 15'h30, 4'hF, 32'h0);
    go();
    clr(0);
    mid();
    chk("lit_be_rv0", obs[0].rv0, 1);
    chk("lit_be_data", obs[0].rd0, 32'hAA22CC44);
    go();

    // out of range
    setm(0, 1, 0, 1, 15'd20490, 4'hF, 32'hDEADBEEF);
    mid();
    chk("lit_oor_wait1", obs[0].w1, 0);
    chk("lit_oor_cs", obs[0].cs, 0);
    go();
    setm(0, 1, 1, 0, 15'd20500, 4'hF, 32'h0);
    mid();
    chk("lit_oor_flag", obs[0].oor, 1);
    chk("lit_oor_rd_cs", obs[0].cs, 0);
    go();
    clr(0);
    mid();
    chk("lit_oor_rv1", obs[0].rv1, 1);
    chk("lit_oor_rd1", obs[0].rd1, 0);
    go();

    // read in flight when hold rises; contested grants resume at m0
    setm(0, 1, 1, 0, 15'h20, 4'hF, 32'h0);
    go();
    stim[0].hold = 1'b1;
    setm(0, 0, 1, 0, 15'h10, 4'hF, 32'h0);
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("lit_hold_wait", {obs[0].w0, obs[0].w1}, 2'b11);
      chk("lit_hold_cs", obs[0].cs, 0);
      chk("lit_hold_rv1", obs[0].rv1, k == 0);
      chk("lit_hold_idle", obs[0].idle, k != 0);
      go();
    end
    stim[0].hold = 1'b0;
    mid();
    chk("lit_unhold_first", {obs[0].w0, obs[0].w1}, 2'b01);
    go();
    mid();
    chk("lit_unhold_second", {obs[0].w0, obs[0].w1}, 2'b10);
    go();
    clr(0);
    mid();
    chk("lit_unhold_rd1", obs[0].rd1, 32'hCAFEF00D);
    go();

    // RD_LATENCY = 2 lane: normal read, then reset with a read in flight
    setm(1, 0, 0, 1, 15'h10, 4'hF, 32'h5A5A0001);
    go();
    setm(1, 0, 1, 0, 15'h10, 4'hF, 32'h0);
    go();
    clr(1);
    mid();
    chk("lit_l2_mid_rv0", obs[1].rv0, 0);
    chk("lit_l2_mid_idle", obs[1].idle, 0);
    go();
    mid();
    chk("lit_l2_rv0", obs[1].rv0, 1);
    chk("lit_l2_rd0", obs[1].rd0, 32'h5A5A0001);
    go();
    setm(1, 1, 1, 0, 15'h10, 4'hF, 32'h0);
    go();
    clr(1);
    stim[1].rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("lit_l2rst_rv", {obs[1].rv0, obs[1].rv1}, 2'b00);
      chk("lit_l2rst_rd1", obs[1].rd1, 0);
      chk("lit_l2rst_wait", {obs[1].w0, obs[1].w1}, 2'b11);
      chk("lit_l2rst_idle", obs[1].idle, 1);
      go();
    end
    stim[1].rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("lit_l2post_rv", {obs[1].rv0, obs[1].rv1}, 2'b00);
      go();
    end

    go();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
